// File: rtl/fp_normalize_if.sv
// Handshake bundle between the linear-sample source, the normalizer and the round stage.
// The slave view belongs to fp_normalize; the master view drives it.
interface fp_normalize_if #(
  parameter int DATA_W = 12,
  parameter int EXP_W  = 3,
  parameter int SIG_W  = 4
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] din;
  logic              out_valid;
  logic              out_ready;
  logic              sign;
  logic [EXP_W-1:0]  exponent;
  logic [SIG_W-1:0]  significand;
  logic              fifthBit;

  modport slave (
    input  in_valid, din, out_ready,
    output in_ready, out_valid, sign, exponent, significand, fifthBit
  );

  modport master (
    output in_valid, din, out_ready,
    input  in_ready, out_valid, sign, exponent, significand, fifthBit
  );
endinterface

// File: rtl/fp_normalize.sv
// Sequential normalizer: sign-magnitude of a two's-complement sample, then a
// one-bit-per-clock leading-one search producing exponent, significand and guard bit.
module fp_normalize #(
  parameter int DATA_W = 12,
  parameter int EXP_W  = 3,
  parameter int SIG_W  = 4
) (
  input logic         clk,
  input logic         rst,
  fp_normalize_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int TOP_B = DATA_W - 2;

  state_t            state_r;
  state_t            state_nxt_s;
  logic [DATA_W-1:0] mag_r;
  logic [EXP_W-1:0]  e_r;
  logic              sign_pend_r;
  logic              accept_s;
  logic              finish_s;
  logic              release_s;
  logic              in_ready_r;
  logic              out_valid_r;
  logic              sign_r;
  logic [EXP_W-1:0]  exponent_r;
  logic [SIG_W-1:0]  significand_r;
  logic              fifth_r;

  // The most negative code has no positive twin, so it clamps to the largest magnitude.
  function automatic logic [DATA_W-1:0] sat_abs(input logic [DATA_W-1:0] x);
    logic [DATA_W-1:0] r;
    if (!x[DATA_W-1]) begin
      r = x;
    end else if (x[DATA_W-2:0] == {(DATA_W-1){1'b0}}) begin
      r = {1'b0, {(DATA_W-1){1'b1}}};
    end else begin
      r = -x;
    end
    return r;
  endfunction

  // Next-state and transfer strobes.
  always_comb begin
    state_nxt_s = state_r;
    accept_s    = 1'b0;
    finish_s    = 1'b0;
    release_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.in_valid) begin
          accept_s    = 1'b1;
          state_nxt_s = SHIFT;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      SHIFT: begin
        if (mag_r[TOP_B] || (e_r == {EXP_W{1'b0}})) begin
          finish_s    = 1'b1;
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = SHIFT;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          release_s   = 1'b1;
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = DONE;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Magnitude/exponent working registers; e_r counts down as mag_r shifts up.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mag_r       <= {DATA_W{1'b0}};
      e_r         <= {EXP_W{1'b0}};
      sign_pend_r <= 1'b0;
    end else if (accept_s) begin
      mag_r       <= sat_abs(bus.din);
      e_r         <= {EXP_W{1'b1}};
      sign_pend_r <= bus.din[DATA_W-1];
    end else if ((state_r == SHIFT) && !finish_s) begin
      mag_r       <= {mag_r[DATA_W-2:0], 1'b0};
      e_r         <= e_r - {{(EXP_W-1){1'b0}}, 1'b1};
    end
  end

  // Registered handshake flags and result fields, held until the round stage takes them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_ready_r    <= 1'b1;
      out_valid_r   <= 1'b0;
      sign_r        <= 1'b0;
      exponent_r    <= {EXP_W{1'b0}};
      significand_r <= {SIG_W{1'b0}};
      fifth_r       <= 1'b0;
    end else begin
      if (accept_s) begin
        in_ready_r <= 1'b0;
      end else if (release_s) begin
        in_ready_r <= 1'b1;
      end
      if (finish_s) begin
        out_valid_r   <= 1'b1;
        sign_r        <= sign_pend_r;
        exponent_r    <= e_r;
        significand_r <= mag_r[TOP_B -: SIG_W];
        fifth_r       <= mag_r[TOP_B-SIG_W];
      end else if (release_s) begin
        out_valid_r   <= 1'b0;
      end
    end
  end

  assign bus.in_ready    = in_ready_r;
  assign bus.out_valid   = out_valid_r;
  assign bus.sign        = sign_r;
  assign bus.exponent    = exponent_r;
  assign bus.significand = significand_r;
  assign bus.fifthBit    = fifth_r;

endmodule

// File: tb/tb_fp_normalize.sv
// Scoreboard bench for fp_normalize: the driver queues expected results, a
// negedge monitor pops and compares each accepted output including latency.
module tb_fp_normalize;

  typedef struct {
    logic [11:0] din;
    logic        s;
    logic [2:0]  ex;
    logic [3:0]  sg;
    logic        f;
    int          lat;
    int          acc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  exp_t sb[$];

  fp_normalize_if bus ();

  fp_normalize dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
    end
  endtask

  // Reference: exponent from the leading-zero count of the 12-bit magnitude.
  function automatic exp_t model(input logic [11:0] d);
    exp_t        r;
    logic [11:0] m;
    logic [11:0] norm;
    logic [11:0] neg;
    int          lz;
    logic        found;
    neg = -d;
    r.din = d;
    r.s = d[11];
    if (!d[11])             m = d;
    else if (d == 12'h800)  m = 12'h7FF;
    else                    m = neg;
    lz = 12;
    found = 1'b0;
    for (int i = 11; i >= 0; i--) begin
      if (!found && m[i]) begin
        lz = 11 - i;
        found = 1'b1;
      end
    end
    if (lz <= 7) begin
      r.ex  = 3'(8 - lz);
      norm  = m << (lz - 1);
      r.sg  = norm[10:7];
      r.f   = norm[6];
      r.lat = lz;
    end else begin
      r.ex  = 3'd0;
      r.sg  = m[3:0];
      r.f   = 1'b0;
      r.lat = 8;
    end
    r.acc = 0;
    return r;
  endfunction

  task automatic send_exp(input exp_t x);
    int   t;
    exp_t y;
    t = 0;
    while (!bus.in_ready && t < 100) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (!bus.in_ready) begin
      chk($sformatf("in_ready_timeout_%03h", x.din), {31'd0, bus.in_ready}, 32'd1);
    end else begin
      bus.din = x.din;
      bus.in_valid = 1'b1;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      y = x;
      y.acc = cyc;
      sb.push_back(y);
    end
  endtask

  task automatic send(input logic [11:0] d);
    send_exp(model(d));
  endtask

  task automatic send_hand(input logic [11:0] d, input logic s, input logic [2:0] e,
                           input logic [3:0] sg, input logic f, input int lat);
    exp_t x;
    x.din = d; x.s = s; x.ex = e; x.sg = sg; x.f = f; x.lat = lat; x.acc = 0;
    send_exp(x);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 200) begin
      @(posedge clk);
      t++;
    end
    chk("drain", sb.size(), 32'd0);
  endtask

  // Monitor: compares at the negedge before each output handshake edge.
  initial begin : monitor
    bit   seen;
    int   rise;
    exp_t x;
    seen = 1'b0;
    rise = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        seen = 1'b0;
      end else if (bus.out_valid) begin
        if (!seen) begin
          seen = 1'b1;
          rise = cyc;
        end
        if (bus.out_ready) begin
          seen = 1'b0;
          if (sb.size() == 0) begin
            chk("unexpected_output", 32'd1, 32'd0);
          end else begin
            x = sb.pop_front();
            chk($sformatf("sign_%03h", x.din), {31'd0, bus.sign}, {31'd0, x.s});
            chk($sformatf("exp_%03h", x.din), {29'd0, bus.exponent}, {29'd0, x.ex});
            chk($sformatf("sig_%03h", x.din), {28'd0, bus.significand}, {28'd0, x.sg});
            chk($sformatf("fifth_%03h", x.din), {31'd0, bus.fifthBit}, {31'd0, x.f});
            chk($sformatf("lat_%03h", x.din), rise - x.acc, x.lat);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    exp_t x;
    int   t;
    bus.in_valid = 1'b0;
    bus.din = 12'h000;
    bus.out_ready = 1'b1;
    rst = 1'b1;
    #1;
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("rst_fields", {23'd0, bus.sign, bus.exponent, bus.significand, bus.fifthBit}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Hand-computed vectors: din, sign, exp, sig, fifth, latency
    send_hand(12'h7FF, 1'b1 ^ 1'b1, 3'd7, 4'b1111, 1'b1, 1);
    send_hand(12'h800, 1'b1, 3'd7, 4'b1111, 1'b1, 1);
    send_hand(12'h00F, 1'b0, 3'd0, 4'b1111, 1'b0, 8);
    send_hand(12'h010, 1'b0, 3'd1, 4'b1000, 1'b0, 7);
    send_hand(12'hF9C, 1'b1, 3'd3, 4'b1100, 1'b1, 5);
    send_hand(12'd422, 1'b0, 3'd5, 4'b1101, 1'b0, 3);
    send_hand(12'h064, 1'b0, 3'd3, 4'b1100, 1'b1, 5);
    send_hand(12'h000, 1'b0, 3'd0, 4'b0000, 1'b0, 8);
    send_hand(12'hFFF, 1'b1, 3'd0, 4'b0001, 1'b0, 8);
    send_hand(12'h400, 1'b0, 3'd7, 4'b1000, 1'b0, 1);
    send_hand(12'h3FF, 1'b0, 3'd6, 4'b1111, 1'b1, 2);
    drain();

    // Back-pressure: result must hold while out_ready is low.
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    send(12'h2A5);
    t = 0;
    while (!bus.out_valid && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("stall_valid_seen", {31'd0, bus.out_valid}, 32'd1);
    x = model(12'h2A5);
    repeat (5) begin
      @(negedge clk);
      chk("stall_out_valid", {31'd0, bus.out_valid}, 32'd1);
      chk("stall_in_ready", {31'd0, bus.in_ready}, 32'd0);
      chk("stall_fields", {23'd0, bus.sign, bus.exponent, bus.significand, bus.fifthBit},
          {23'd0, x.s, x.ex, x.sg, x.f});
    end
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("release_in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("release_out_valid", {31'd0, bus.out_valid}, 32'd0);
    drain();

    // Asynchronous reset in the middle of a long shift sequence.
    send(12'h001);
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("midrst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("midrst_fields", {23'd0, bus.sign, bus.exponent, bus.significand, bus.fifthBit}, 32'd0);
    sb.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    send_hand(12'hF9C, 1'b1, 3'd3, 4'b1100, 1'b1, 5);
    drain();

    // Exhaustive sweep against the reference model.
    for (int d = 0; d < 4096; d++) begin
      send(12'(d));
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
